// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and constants for the SPI register file
//
// Purpose: FSM state encoding, header field positions and default geometry
// for spi_reg_file, plus a helper that classifies a header byte.
// Ports: none (package).

package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_DATA    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    localparam int HDR_WR_BIT  = 7;
    localparam int HDR_RSV_MSB = 6;
    localparam int HDR_RSV_LSB = 4;

    localparam int NREGS_DEF  = 16;
    localparam int ADDR_W_DEF = 4;

    // A header is accepted only when it is a write and the reserved field is zero.
    function automatic logic hdr_is_valid(input logic [7:0] b);
        return b[HDR_WR_BIT] && (b[HDR_RSV_MSB:HDR_RSV_LSB] == '0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, async active-low reset to 1
//
// Purpose: brings an asynchronous level (e.g. SPI chip-select) into the clk
// domain. Reset value is 1 so an active-low select reads as deasserted.
// Ports:
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset
//   i_d      asynchronous input
//   o_q      synchronized output (2-cycle latency)

module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spi_reg_file.sv
// rtl/spi_reg_file.sv - framed SPI write-command parser into a 16 x 8 register file
//
// Purpose: consumes bytes from spi_slave; each SSEL-delimited frame carries a
// header {1,000,addr} followed by data bytes written to the register file.
// Bad headers are discarded and counted (saturating).
// Build option: SPI_REG_AUTOINC_EN - when defined, data bytes burst-write with
// an auto-incrementing address (wrapping); when undefined, only the first data
// byte of a frame is written.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   SSEL         raw active-low chip-select (asynchronous)
//   cmd          received byte, cmd_valid one-cycle strobe per byte
//   regs         flattened register file, reg i at [8*i+7:8*i]
//   wr_pulse     one-cycle write strobe with wr_addr / wr_data
//   err_count    saturating count of rejected headers
//   busy         frame open (synchronized SSEL low)

module spi_reg_file
    import spi_reg_pkg::*;
#(
    parameter int         NREGS   = NREGS_DEF,
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SSEL,
    input  logic [7:0]           cmd,
    input  logic                 cmd_valid,
    output logic [8*NREGS-1:0]   regs,
    output logic                 wr_pulse,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [7:0]           wr_data,
    output logic [7:0]           err_count,
    output logic                 busy
);

    logic               w_ssel_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_ptr;
    logic [8*NREGS-1:0] r_regs;
    logic               r_wr_pulse;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [7:0]         r_wr_data;
    logic [7:0]         r_err_count;
    logic               w_wr_en;
    logic               w_ptr_load;
    logic               w_err_inc;

    sync_2ff u_ssel_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (SSEL),
        .o_q     (w_ssel_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_ptr_load  = 1'b0;
        w_err_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_ssel_s) begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (cmd_valid) begin
                    if (hdr_is_valid(cmd)) begin
                        w_ptr_load  = 1'b1;
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_err_inc   = 1'b1;
                        w_state_nxt = ST_DISCARD;
                    end
                end
            end
            ST_DATA: begin
                if (cmd_valid) begin
                    w_wr_en = 1'b1;
`ifndef SPI_REG_AUTOINC_EN
                    w_state_nxt = ST_DISCARD;
`endif
                end
            end
            default: begin
                // ST_DISCARD: swallow bytes until the frame closes
            end
        endcase
        // The byte of this cycle is still handled above; closing the frame wins
        // only for the state transition.
        if ((r_state != ST_IDLE) && w_ssel_s) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_regs      <= {NREGS{RST_VAL}};
            r_wr_pulse  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
            r_err_count <= 8'h00;
        end else begin
            r_wr_pulse <= w_wr_en;
            if (w_ptr_load) begin
                r_ptr <= cmd[ADDR_W-1:0];
            end
`ifdef SPI_REG_AUTOINC_EN
            else if (w_wr_en) begin
                r_ptr <= r_ptr + 1'b1;
            end
`endif
            if (w_wr_en) begin
                r_regs[8*r_ptr +: 8] <= cmd;
                r_wr_addr            <= r_ptr;
                r_wr_data            <= cmd;
            end
            if (w_err_inc && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign regs      = r_regs;
    assign wr_pulse  = r_wr_pulse;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign err_count = r_err_count;
    assign busy      = ~w_ssel_s;

endmodule

// File: doc/spi_reg_file.md
# spi_reg_file

Byte-stream command consumer that sits directly downstream of `spi_slave`: takes each received byte (`cmd`/`cmd_valid`) plus the raw chip-select, and parses framed write commands into a 16 x 8-bit register file. The register contents drive the board-level control outputs (LEDs, mode bits). Frames are delimited by SSEL. Illegal headers are counted and discarded.

## Interface
- `NREGS`, 16, number of registers; power of two, fixed at 16 in this revision.
- `ADDR_W`, 4, register address width, equal to log2(`NREGS`).
- `RST_VAL`, 8'h00, reset value of every register.

Ports:
- `clk`  in  1  system clock, the same clock as `spi_slave`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SSEL`  in  1  raw SPI chip-select, active low, asynchronous to `clk`.
- `cmd`  in  8  received byte from `spi_slave`.
- `cmd_valid`  in  1  one-`clk` pulse per received byte; `cmd` is stable while it is high.
- `regs`  out  8*NREGS  flattened register file; register i is at `[8*i+7:8*i]`.
- `wr_pulse`  out  1  one-cycle strobe for each register write.
- `wr_addr`  out  ADDR_W  address of the current write; valid while `wr_pulse` is high.
- `wr_data`  out  8  data of the current write; valid while `wr_pulse` is high.
- `err_count`  out  8  number of bad headers; saturates at 8'hFF.
- `busy`  out  1  high while a frame is open (synchronized SSEL is low).

## Operation
- Frame format:
  - Byte 0 is the header `{1'b1, 3'b000, addr[3:0]}`. Bit 7 set means write. Bits 6:4 are reserved and must be 0.
  - Bytes 1..n are data bytes.
- SSEL is passed through a 2-flop synchronizer. `ssel_s` is the synchronized value, active low.
- FSM states:
  - IDLE: `ssel_s` high.
  - HDR: waiting for the header.
  - DATA: writing data bytes.
  - DISCARD: frame rejected.
- Transitions:
  - IDLE -> HDR when `ssel_s` goes low.
  - HDR + valid header byte -> DATA. The address pointer `ptr` is loaded from `addr`.
  - HDR + header with bit 7 = 0 or reserved bits != 0 -> DISCARD. `err_count` increments.
  - DATA + byte: `regs[ptr]` <= `cmd`, `wr_pulse` asserts, and `ptr` advances (see Configuration).
  - Any state except IDLE, with `ssel_s` high -> IDLE.
- Simultaneous byte and deassert: if `cmd_valid` and the `ssel_s` rising edge land in the same cycle, the byte is processed first using current-state rules, then the FSM enters IDLE.
- `cmd_valid` while in IDLE is ignored.
- Registers change only on DATA-state writes.

## Timing
- Reset values:
  - All `regs` = `RST_VAL`.
  - `wr_pulse` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `err_count` = 0, `busy` = 0.
  - FSM in IDLE, synchronizer flops at 1.
- Write latency: `cmd_valid` high at edge N gives a register update, `wr_pulse`, `wr_addr` and `wr_data` all visible after edge N+1. `wr_pulse` is high for exactly one cycle.
- Throughput: one byte per `clk` is accepted. Back-to-back `cmd_valid` pulses must all be written.
- `busy` follows `ssel_s` inverted, with a 2-cycle synchronizer delay.
- Mid-frame reset: `rst_n` low asynchronously clears everything.
  - After release, the FSM waits in IDLE until a fresh SSEL falling edge.
  - If SSEL is already low at release, the synchronizer reads low after 2 cycles, the FSM enters HDR, and the next byte is taken as a header.
- `err_count` stays at 8'hFF once reached.

## Configuration
- `SPI_REG_AUTOINC_EN` defined (burst mode):
  - After each DATA write, `ptr` <= `ptr` + 1 modulo `NREGS`, wrapping 15 -> 0.
  - Any number of data bytes is accepted per frame.
- `SPI_REG_AUTOINC_EN` undefined (single-write mode):
  - After the first data byte the FSM enters DISCARD.
  - Further bytes in the frame are ignored without writes.
  - Extra bytes do not increment `err_count`.

## Structure
- Package `spi_reg_pkg` holds:
  - the FSM state encoding (IDLE/HDR/DATA/DISCARD, 2 bits);
  - the header field constants: `HDR_WR_BIT` = 7, `HDR_RSV_MSB` = 6, `HDR_RSV_LSB` = 4;
  - the default `NREGS`/`ADDR_W`.
- Sub-module `sync_2ff` is a 2-flop synchronizer with an async active-low reset and reset value 1. It is used for SSEL and is reusable elsewhere.

## Test plan
- Reset, then read `regs` -> all bytes 8'h00; `err_count` = 0; `busy` = 0.
- Frame `{8'h83, 8'hEA}` -> reg3 = 8'hEA; one `wr_pulse` with `wr_addr` = 3 and `wr_data` = 8'hEA, one cycle after `cmd_valid`; other registers unchanged.
- Frame `{8'h8F, 8'h11, 8'h22}`:
  - with `SPI_REG_AUTOINC_EN`: reg15 = 8'h11, reg0 = 8'h22 (wrap), two `wr_pulse`.
  - without `SPI_REG_AUTOINC_EN`: reg15 = 8'h11, reg0 unchanged, one `wr_pulse`.
- Frame `{8'h93, 8'h55}` (reserved bit set) and frame `{8'h03, 8'h55}` (read) -> no writes; `err_count` = 2; reg3 keeps its prior value.
- SSEL deasserted after `{8'h82}` and reasserted, then `{8'h84, 8'h77}` -> only reg4 = 8'h77; reg2 unchanged.
- `rst_n` pulsed low between header 8'h81 and data 8'h99 (SSEL held low) -> reg1 = 8'h00; the 8'h99 byte is treated as a header and counted as an error (`err_count` = 1).
